// File: rtl/fetch_unit.sv
// fetch_unit: fetch/exec/halt FSM that sequences the PC, latches instructions and counts retired instructions
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] imemaddr,
  output logic [31:0] Instr,
  output logic        instr_valid,
  input  logic        PCSrc,
  input  logic        BNE,
  input  logic        zero,
  input  logic [1:0]  JumpSel,
  input  logic [15:0] Imm,
  input  logic [31:0] rs_data,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        dhit,
  input  logic        Halt,
  output logic [31:0] pc_plus4,
  output logic        halt,
  output logic [31:0] retired
);
  typedef enum logic [1:0] {FETCH, EXEC, HALTED} state_e;
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, ret_q, ret_d, npc;
  logic taken;
  assign iREN        = state_q == FETCH;
  assign instr_valid = state_q == EXEC;
  assign halt        = state_q == HALTED;
  assign imemaddr    = pc_q;
  assign Instr       = instr_q;
  assign retired     = ret_q;
  assign pc_plus4    = pc_q + 32'd4;
  always_comb begin
    taken   = PCSrc & (zero ^ BNE);
    npc     = JumpSel == 2'b01 ? {pc_plus4[31:28], instr_q[25:0], 2'b00} :
              JumpSel == 2'b10 ? {rs_data[31:2], 2'b00} :
              taken            ? pc_plus4 + {{14{Imm[15]}}, Imm, 2'b00} : pc_plus4;
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ret_d   = ret_q;
    if (state_q == FETCH && ihit) begin
      instr_d = imemload;
      state_d = EXEC;
    end else if (state_q == EXEC) begin
      if (Halt) state_d = HALTED;
      else if (!((dREN | dWEN) & ~dhit)) begin
        pc_d    = npc;
        ret_d   = ret_q + 32'd1;
        state_d = FETCH;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      instr_q <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ret_q   <= ret_d;
    end
  end
endmodule
